// File: rtl/noise_source.sv
// Triangle test signal corrupted by FIR-coloured LFSR noise, emitted in bursts.
// Provides the reference noise, the corrupted signal and the clean signal per strobe.
//
// state | meaning
// IDLE  | after reset; outputs hold, waiting for start
// RUN   | divider running, one sample per DIV cycles
// DONE  | burst complete or stopped; outputs hold, start re-arms
module noise_source #(
    parameter int                            DATA_WIDTH = 16,
    parameter int                            DIV        = 4,
    parameter logic [15:0]                   LFSR_SEED  = 16'hACE1,
    parameter logic signed [DATA_WIDTH-1:0]  H0         = 16'sh4000,
    parameter logic signed [DATA_WIDTH-1:0]  H1         = 16'sh2000,
    parameter logic signed [DATA_WIDTH-1:0]  H2         = -16'sh1000,
    parameter logic signed [DATA_WIDTH-1:0]  H3         = 16'sh0800,
    parameter logic signed [DATA_WIDTH-1:0]  TRI_STEP   = 16'sd256,
    parameter logic signed [DATA_WIDTH-1:0]  TRI_AMP    = 16'sd8192
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [15:0]                   num_samples,
    input  logic                          stop,
    output logic                          sample_en,
    output logic signed [DATA_WIDTH-1:0]  ref_s,
    output logic signed [DATA_WIDTH-1:0]  d,
    output logic signed [DATA_WIDTH-1:0]  s_clean,
    output logic                          busy,
    output logic                          done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int PW = 2 * DATA_WIDTH;
    localparam int AW = 2 * DATA_WIDTH + 2;
    localparam int EW = DATA_WIDTH + 1;
    localparam logic [7:0] DIV_M1 = 8'(DIV - 1);

    localparam logic signed [AW-1:0] ACC_MAX = {{(AW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] ACC_MIN = {{(AW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [AW-1:0] v);
        if (v > ACC_MAX) return ACC_MAX[DATA_WIDTH-1:0];
        if (v < ACC_MIN) return ACC_MIN[DATA_WIDTH-1:0];
        return v[DATA_WIDTH-1:0];
    endfunction

    logic [1:0]                   state;
    logic [15:0]                  lfsr;
    logic [7:0]                   div_q;
    logic [15:0]                  cnt_q;
    logic [15:0]                  len_q;
    logic signed [DATA_WIDTH-1:0] n1, n2, n3;
    logic signed [DATA_WIDTH-1:0] tri_q;
    logic                         rising;

    logic [15:0]                  lfsr_nxt;
    logic signed [15:0]           lfsr_sh;
    logic signed [DATA_WIDTH-1:0] n_new, c_new, s_new, d_new;
    logic signed [PW-1:0]         p0, p1, p2, p3;
    logic signed [AW-1:0]         acc;
    logic signed [EW-1:0]         tri_up, tri_dn, sd_sum;
    logic                         rising_nxt;

    always_comb begin
        lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        lfsr_sh  = $signed(lfsr_nxt) >>> 2;
        n_new    = DATA_WIDTH'(lfsr_sh);

        p0    = PW'(H0) * PW'(n_new);
        p1    = PW'(H1) * PW'(n1);
        p2    = PW'(H2) * PW'(n2);
        p3    = PW'(H3) * PW'(n3);
        acc   = AW'(p0) + AW'(p1) + AW'(p2) + AW'(p3);
        c_new = sat(acc >>> 15);

        // Triangle turns around on the sample that reaches the peak
        tri_up     = EW'(tri_q) + EW'(TRI_STEP);
        tri_dn     = EW'(tri_q) - EW'(TRI_STEP);
        s_new      = tri_q;
        rising_nxt = rising;
        if (rising) begin
            if (tri_up >= EW'(TRI_AMP)) begin
                s_new      = TRI_AMP;
                rising_nxt = 1'b0;
            end else begin
                s_new = tri_up[DATA_WIDTH-1:0];
            end
        end else begin
            if (tri_dn <= -EW'(TRI_AMP)) begin
                s_new      = -TRI_AMP;
                rising_nxt = 1'b1;
            end else begin
                s_new = tri_dn[DATA_WIDTH-1:0];
            end
        end

        sd_sum = EW'(s_new) + EW'(c_new);
        d_new  = sat(AW'(sd_sum));
    end

    assign busy = (state == ST_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            lfsr      <= LFSR_SEED;
            div_q     <= '0;
            cnt_q     <= '0;
            len_q     <= '0;
            n1        <= '0;
            n2        <= '0;
            n3        <= '0;
            tri_q     <= '0;
            rising    <= 1'b1;
            sample_en <= 1'b0;
            done      <= 1'b0;
            ref_s     <= '0;
            d         <= '0;
            s_clean   <= '0;
        end else begin
            sample_en <= 1'b0;
            done      <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state  <= ST_RUN;
                        lfsr   <= LFSR_SEED;
                        div_q  <= '0;
                        cnt_q  <= '0;
                        len_q  <= num_samples;
                        n1     <= '0;
                        n2     <= '0;
                        n3     <= '0;
                        tri_q  <= '0;
                        rising <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // stop and burst completion both take priority over a due strobe
                    if (stop || (len_q != 16'd0 && cnt_q == len_q)) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else if (div_q == DIV_M1) begin
                        div_q     <= '0;
                        cnt_q     <= cnt_q + 16'd1;
                        sample_en <= 1'b1;
                        lfsr      <= lfsr_nxt;
                        n1        <= n_new;
                        n2        <= n1;
                        n3        <= n2;
                        tri_q     <= s_new;
                        rising    <= rising_nxt;
                        ref_s     <= n_new;
                        s_clean   <= s_new;
                        d         <= d_new;
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_noise_source.sv
// Directed bench for noise_source: burst timing, first-sample values, triangle shape,
// saturation, stop/start interplay and mid-burst reset, against a small behavioural model.
module tb_noise_source;

    logic        clk = 1'b0;
    logic        rst, start, stop;
    logic [15:0] num_samples;

    logic        se_a, busy_a, done_a;
    logic [15:0] ref_a, d_a, s_a;
    logic        se_b, busy_b, done_b;
    logic [15:0] ref_b, d_b, s_b;
    logic        se_c, busy_c, done_c;
    logic [15:0] ref_c, d_c, s_c;

    int n_chk  = 0;
    int n_fail = 0;
    int sat_hits = 0;

    typedef struct packed {
        logic [15:0] lfsr;
        int          n1;
        int          n2;
        int          n3;
        int          s;
        logic        up;
    } mdl_t;

    mdl_t m_a, m_b, m_c;

    always #5 clk = ~clk;

    noise_source u_def (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples), .stop(stop),
        .sample_en(se_a), .ref_s(ref_a), .d(d_a), .s_clean(s_a), .busy(busy_a), .done(done_a)
    );

    noise_source #(.TRI_AMP(16'sd512), .TRI_STEP(16'sd256)) u_tri (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples), .stop(stop),
        .sample_en(se_b), .ref_s(ref_b), .d(d_b), .s_clean(s_b), .busy(busy_b), .done(done_b)
    );

    noise_source #(.H0(16'sh7FFF), .TRI_AMP(16'sh7F00)) u_sat (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples), .stop(stop),
        .sample_en(se_c), .ref_s(ref_c), .d(d_c), .s_clean(s_c), .busy(busy_c), .done(done_c)
    );

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic longint clamp16(input longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic mdl_t mdl_init();
        mdl_t m;
        m.lfsr = 16'hACE1;
        m.n1 = 0; m.n2 = 0; m.n3 = 0;
        m.s  = 0;
        m.up = 1'b1;
        return m;
    endfunction

    task automatic mdl_step(inout mdl_t m, input int h0, input int amp,
                            output int n, output int s, output int dv);
        longint acc, cv;
        m.lfsr = {m.lfsr[14:0], ^(m.lfsr & 16'hB400)};
        n   = int'($signed(m.lfsr)) >>> 2;
        acc = longint'(h0) * n + 64'sd8192 * m.n1 - 64'sd4096 * m.n2 + 64'sd2048 * m.n3;
        cv  = clamp16(acc >>> 15);
        m.n3 = m.n2; m.n2 = m.n1; m.n1 = n;
        if (m.up) begin
            m.s += 256;
            if (m.s >= amp) begin m.s = amp; m.up = 1'b0; end
        end else begin
            m.s -= 256;
            if (m.s <= -amp) begin m.s = -amp; m.up = 1'b1; end
        end
        s  = m.s;
        dv = int'(clamp16(longint'(m.s) + cv));
    endtask

    task automatic chk_out(input string tag, inout mdl_t m, input int h0, input int amp,
                           input logic [15:0] r, input logic [15:0] dd, input logic [15:0] ss);
        int n, s, dv;
        mdl_step(m, h0, amp, n, s, dv);
        if (dv == 32767) sat_hits++;
        chk({tag, "_ref"}, $signed(r), n);
        chk({tag, "_s"}, $signed(ss), s);
        chk({tag, "_d"}, $signed(dd), dv);
    endtask

    // One burst of n samples from IDLE/DONE; strobe, busy and done checked every cycle
    task automatic burst(input int n, input string tag);
        int strobes;
        bit exp_se, exp_busy, exp_done;
        int tri_tab[8] = '{256, 512, 256, 0, -256, -512, -256, 0};
        num_samples = 16'(n);
        start = 1'b1;
        step();
        start = 1'b0;
        m_a = mdl_init(); m_b = mdl_init(); m_c = mdl_init();
        strobes = 0;
        for (int c = 1; c <= 4 * n + 4; c++) begin
            step();
            exp_se   = (c % 4 == 0) && (c <= 4 * n);
            exp_busy = (c <= 4 * n);
            exp_done = (c == 4 * n + 1);
            chk({tag, "_se_def"}, se_a, exp_se);
            chk({tag, "_se_tri"}, se_b, exp_se);
            chk({tag, "_se_sat"}, se_c, exp_se);
            chk({tag, "_busy_def"}, busy_a, exp_busy);
            chk({tag, "_busy_tri"}, busy_b, exp_busy);
            chk({tag, "_busy_sat"}, busy_c, exp_busy);
            chk({tag, "_done_def"}, done_a, exp_done);
            chk({tag, "_done_tri"}, done_b, exp_done);
            chk({tag, "_done_sat"}, done_c, exp_done);
            if (se_a) begin
                strobes++;
                if (strobes == 1) begin
                    chk({tag, "_first_ref"}, $signed(ref_a), 16'sh1670);
                    chk({tag, "_first_s"}, $signed(s_a), 256);
                    chk({tag, "_first_d"}, $signed(d_a), 3128);
                    chk({tag, "_first_d_sat"}, $signed(d_c), 5999);
                end
                if (n == 8) chk({tag, "_tri_shape"}, $signed(s_b), tri_tab[strobes-1]);
                chk_out({tag, "_def"}, m_a, 16384, 8192, ref_a, d_a, s_a);
                chk_out({tag, "_tri"}, m_b, 16384, 512, ref_b, d_b, s_b);
                chk_out({tag, "_sat"}, m_c, 32767, 32512, ref_c, d_c, s_c);
            end
        end
        chk({tag, "_strobes"}, strobes, n);
        chk({tag, "_hold_ref"}, $signed(ref_a), m_a.n1);
        chk({tag, "_hold_s"}, $signed(s_a), m_a.s);
    endtask

    initial begin
        int strobes;
        rst = 1'b1; start = 1'b0; stop = 1'b0; num_samples = 16'd0;
        repeat (3) step();
        chk("rst_se", se_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_ref", $signed(ref_a), 0);
        chk("rst_d", $signed(d_a), 0);
        chk("rst_s", $signed(s_a), 0);
        chk("rst_d_sat", $signed(d_c), 0);
        rst = 1'b0;
        step();

        burst(3, "b3");
        burst(8, "b8");

        // Continuous run, stop lands on the 6th due strobe together with a start
        num_samples = 16'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        m_a = mdl_init();
        strobes = 0;
        for (int c = 1; c <= 23; c++) begin
            step();
            if (se_a) begin
                strobes++;
                chk_out("cont", m_a, 16384, 8192, ref_a, d_a, s_a);
            end
        end
        chk("cont_busy", busy_a, 1);
        stop = 1'b1; start = 1'b1;
        step();
        stop = 1'b0; start = 1'b0;
        chk("stop_se", se_a, 0);
        chk("stop_done", done_a, 1);
        chk("stop_busy", busy_a, 0);
        chk("stop_cnt", strobes, 5);
        step();
        chk("stop_start_ign", busy_a, 0);
        chk("stop_done_pulse", done_a, 0);
        chk("stop_hold_ref", $signed(ref_a), m_a.n1);

        burst(3, "restart");

        // Reset mid-burst, spanning a due strobe
        num_samples = 16'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (10) step();
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("mid_rst_se", se_a, 0);
            chk("mid_rst_busy", busy_a, 0);
            chk("mid_rst_ref", $signed(ref_a), 0);
        end
        rst = 1'b0;
        step();
        burst(3, "post_rst");

        sat_hits = 0;
        burst(140, "sat");
        $display("saturated samples seen in long burst: %0d", sat_hits);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
